regsel_demux3: RTL and testbench



---
 rtl/regsel_demux3.sv | 134 +++++++++++++
 tb/tb_regsel_demux3.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regsel_demux3.sv
// rtl/regsel_demux3.sv - routes register-number tokens to one of three FIFO-buffered channels
//
// Purpose:
//   Distributes a stream of W-bit register-number tokens to three destination
//   channels by a 2-bit per-token select. Each channel owns a 2-entry FIFO, so
//   a stalled consumer blocks only its own channel. Select code 3 is illegal:
//   the token is accepted, dropped, and counted.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready         producer handshake
//   in_data [W-1:0]           token
//   in_sel  [1:0]             destination channel (3 = illegal)
//   outK_valid/outK_ready     consumer K handshake (K = 0, 1, 2)
//   outK_data [W-1:0]         channel K head token
//   err_pulse                 registered one-cycle pulse per illegal token
//   err_count [7:0]           saturating illegal-token count
module regsel_demux3 #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_sel,
  output logic         out0_valid,
  output logic [W-1:0] out0_data,
  input  logic         out0_ready,
  output logic         out1_valid,
  output logic [W-1:0] out1_data,
  input  logic         out1_ready,
  output logic         out2_valid,
  output logic [W-1:0] out2_data,
  input  logic         out2_ready,
  output logic         err_pulse,
  output logic [7:0]   err_count
);

  logic [W-1:0] mem_q [3][2];
  logic [W-1:0] mem_d [3][2];
  logic [2:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   cnt_q [3];
  logic [1:0]   cnt_d [3];
  logic         err_pulse_q, err_pulse_d;
  logic [7:0]   err_count_q, err_count_d;

  logic [2:0]   push;
  logic [2:0]   pop;
  logic [2:0]   out_ready;
  logic [2:0]   out_valid;

  assign out_ready = {out2_ready, out1_ready, out0_ready};

  // in_ready looks only at registered occupancy and in_sel, never at any
  // outK_ready, so a full channel refuses a push even while it is draining.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = (cnt_q[0] != 2'd2);
      2'd1:    in_ready = (cnt_q[1] != 2'd2);
      2'd2:    in_ready = (cnt_q[2] != 2'd2);
      default: in_ready = 1'b1;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    push     = '0;
    pop      = '0;
    out_valid = '0;
    for (int k = 0; k < 3; k++) begin
      out_valid[k] = (cnt_q[k] != 2'd0);
      push[k]      = in_valid & in_ready & (in_sel == k[1:0]);
      pop[k]       = out_valid[k] & out_ready[k];
      if (push[k]) begin
        mem_d[k][wr_ptr_q[k]] = in_data;
        wr_ptr_d[k]           = ~wr_ptr_q[k];
      end
      if (pop[k]) begin
        rd_ptr_d[k] = ~rd_ptr_q[k];
      end
      case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + 2'd1;
        2'b01:   cnt_d[k] = cnt_q[k] - 2'd1;
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  // Illegal tokens are always accepted, so in_valid alone qualifies them.
  always_comb begin
    err_pulse_d = in_valid & (in_sel == 2'd3);
    err_count_d = err_count_q;
    if (err_pulse_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '{default: 2'd0};
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  // Storage needs no reset: an entry is only visible while its count is nonzero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out0_valid = out_valid[0];
  assign out1_valid = out_valid[1];
  assign out2_valid = out_valid[2];
  assign out0_data  = mem_q[0][rd_ptr_q[0]];
  assign out1_data  = mem_q[1][rd_ptr_q[1]];
  assign out2_data  = mem_q[2][rd_ptr_q[2]];
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_regsel_demux3.sv
// tb/tb_regsel_demux3.sv - directed self-checking bench for regsel_demux3
module tb_regsel_demux3;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         out0_valid, out1_valid, out2_valid;
  logic [W-1:0] out0_data, out1_data, out2_data;
  logic         out0_ready, out1_ready, out2_ready;
  logic         err_pulse;
  logic [7:0]   err_count;

  int passed = 0;
  int total  = 0;

  regsel_demux3 #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .out2_valid (out2_valid),
    .out2_data  (out2_data),
    .out2_ready (out2_ready),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_sel = 2'd0;
    out0_ready = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
    #2;
    chk("rst_in_ready_sel0", in_ready, 1);
    in_sel = 2'd3;
    #1;
    chk("rst_in_ready_sel3", in_ready, 1);
    in_sel = 2'd0;
    step(); step();
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out2_valid", out2_valid, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;

    // single token to channel 1
    in_valid = 1'b1; in_sel = 2'd1; in_data = 5'd31;
    #1;
    chk("t1_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t1_out1_valid", out1_valid, 1);
    chk("t1_out1_data", out1_data, 31);
    chk("t1_out0_valid", out0_valid, 0);
    chk("t1_out2_valid", out2_valid, 0);
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;
    chk("t1_out1_drained", out1_valid, 0);

    // channel 2 backpressure
    in_valid = 1'b1; in_sel = 2'd2; in_data = 5'd7;
    #1; chk("t2_ready_7", in_ready, 1);
    step();
    in_data = 5'd8;
    #1; chk("t2_ready_8", in_ready, 1);
    step();
    in_data = 5'd9;
    #1; chk("t2_full_ready", in_ready, 0);
    chk("t2_head_7", out2_data, 7);
    out2_ready = 1'b1;
    #1; chk("t2_full_ready_while_pop", in_ready, 0);
    step();
    chk("t2_head_8", out2_data, 8);
    chk("t2_ready_9", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t2_valid_9", out2_valid, 1);
    chk("t2_head_9", out2_data, 9);
    step();
    out2_ready = 1'b0;
    chk("t2_empty", out2_valid, 0);

    // streaming throughput on channel 0
    out0_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_sel = 2'd0; in_data = i[W-1:0];
      #1;
      chk("t3_in_ready", in_ready, 1);
      if (i > 0) begin
        chk("t3_out0_valid", out0_valid, 1);
        chk("t3_out0_data", out0_data, i - 1);
      end
      step();
    end
    in_valid = 1'b0;
    chk("t3_last_valid", out0_valid, 1);
    chk("t3_last_data", out0_data, 15);
    step();
    chk("t3_empty", out0_valid, 0);
    out0_ready = 1'b0;

    // illegal select, saturating counter
    in_valid = 1'b1; in_sel = 2'd3; in_data = 5'd4;
    for (int i = 0; i < 257; i++) begin
      #1;
      chk("t4_in_ready", in_ready, 1);
      step();
      chk("t4_err_pulse", err_pulse, 1);
      chk("t4_err_count", err_count, (i + 1 > 255) ? 255 : i + 1);
    end
    in_valid = 1'b0;
    step();
    chk("t4_err_pulse_off", err_pulse, 0);
    chk("t4_err_count_final", err_count, 255);
    chk("t4_out0_valid", out0_valid, 0);
    chk("t4_out1_valid", out1_valid, 0);
    chk("t4_out2_valid", out2_valid, 0);

    // asynchronous reset mid-stream
    in_valid = 1'b1; in_sel = 2'd1; in_data = 5'd3;
    step();
    in_data = 5'd5;
    step();
    in_valid = 1'b0;
    chk("t5_out1_head_3", out1_data, 3);
    rst = 1'b1;
    #2;
    chk("t5_async_clear", out1_valid, 0);
    chk("t5_err_count_clear", err_count, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 5'd6;
    step();
    in_valid = 1'b0;
    chk("t5_out1_valid", out1_valid, 1);
    chk("t5_out1_data", out1_data, 6);
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;
    chk("t5_single_entry", out1_valid, 0);

    // interleaved channels, channel 1 stalled
    out0_ready = 1'b1; out1_ready = 1'b0; out2_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 5'd1;
    step();
    in_sel = 2'd1; in_data = 5'd2;
    chk("t6_ch0_first", out0_data, 1);
    chk("t6_ch0_first_v", out0_valid, 1);
    step();
    in_sel = 2'd2; in_data = 5'd3;
    chk("t6_ch0_drained", out0_valid, 0);
    chk("t6_ch1_hold_a", out1_data, 2);
    step();
    in_sel = 2'd0; in_data = 5'd4;
    chk("t6_ch2_data", out2_data, 3);
    chk("t6_ch2_valid", out2_valid, 1);
    chk("t6_ch1_hold_b", out1_data, 2);
    step();
    in_valid = 1'b0;
    chk("t6_ch0_second", out0_data, 4);
    chk("t6_ch2_drained", out2_valid, 0);
    chk("t6_ch1_hold_c", out1_data, 2);
    step();
    chk("t6_ch0_empty", out0_valid, 0);
    chk("t6_ch1_hold_v", out1_valid, 1);
    chk("t6_ch1_hold_d", out1_data, 2);
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;
    chk("t6_ch1_drained", out1_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
